// File: rtl/rapids_pkg.sv
// rtl/rapids_pkg.sv - shared types for the instruction fetch path
package rapids_pkg;

    localparam int WORD_W = 32;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
        logic              fault;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry fetch FIFO with registered head
//
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   push           write entry into the tail
//   entry_in       entry written on push
//   pop            remove the head entry (ignored when empty)
//   flush          drop all entries; wins over push and pop
//   count          number of stored entries
//   head           head entry, taken straight from a register
//   head_valid     count is non-zero
module fetch_fifo
    import rapids_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  fetch_entry_t     entry_in,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head,
    output logic             head_valid
);

    // Shift-register organisation: slot 0 is always the head, so the
    // head outputs come directly from flops with no read mux.
    fetch_entry_t     ent      [DEPTH];
    fetch_entry_t     ent_next [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] wr_idx;
    logic             pop_ok;

    always_comb begin
        pop_ok = pop && (cnt != '0);
        // Tail slot after this cycle's shift.
        wr_idx = cnt - CNT_W'(pop_ok);
        for (int i = 0; i < DEPTH; i++) begin
            ent_next[i] = ent[i];
        end
        if (pop_ok) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                ent_next[i] = ent[i + 1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_idx == CNT_W'(i))) begin
                ent_next[i] = entry_in;
            end
        end
        cnt_next = cnt + CNT_W'(push) - CNT_W'(pop_ok);
        if (flush) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
            cnt <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= ent_next[i];
            end
            cnt <= cnt_next;
        end
    end

    assign count      = cnt;
    assign head       = ent[0];
    assign head_valid = (cnt != '0);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with output buffer and redirect
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   instr_addr   out          word address to the MMU instruction port
//   instr        in           instruction word, valid one cycle after issue
//   wait_instr   in           MMU stall; current address not accepted
//   instr_segv   in           fault flag for the current instr_addr
//   redirect     in           flush and restart at redirect_pc
//   redirect_pc  in           restart word address
//   out_valid/out_ready       head entry handshake towards decode
//   out_instr/out_pc/out_fault head entry contents
module fetch_unit
    import rapids_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'd32,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [WORD_W-1:0] instr_addr,
    input  logic [WORD_W-1:0] instr,
    input  logic              wait_instr,
    input  logic              instr_segv,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_instr,
    output logic [WORD_W-1:0] out_pc,
    output logic              out_fault
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [WORD_W-1:0] pc;
    logic              inflight;
    logic [WORD_W-1:0] inflight_pc;
    logic              inflight_fault;
    logic [CNT_W-1:0]  count;
    logic [OCC_W-1:0]  occupancy;
    logic              issue;
    logic              push;
    logic              pop;
    fetch_entry_t      entry_in;
    fetch_entry_t      head;

    assign pop  = out_valid && out_ready;
    assign push = inflight && !redirect;
    assign entry_in = '{instr: instr, pc: inflight_pc, fault: inflight_fault};

    // Buffered plus in-flight entries after this cycle's pop; issuing only
    // below DEPTH reserves a slot for the word that lands next cycle.
    assign occupancy = {1'b0, count} + OCC_W'(inflight) - OCC_W'(pop);
    assign issue = (state == RUN) && !wait_instr && !redirect &&
                   (occupancy < OCC_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = RUN;
        end else if (issue && instr_segv) begin
            state_next = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc             <= RESET_PC;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_fault <= 1'b0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc    <= pc;
                inflight_fault <= instr_segv;
                pc             <= pc + 1'b1;
            end
        end
    end

    assign instr_addr = pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .entry_in   (entry_in),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head       (head),
        .head_valid (out_valid)
    );

    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign out_fault = head.fault;

endmodule
